accel_sequencer: RTL and testbench
==================================

Name: accel_sequencer

Overview:
Job-level controller driving the buffer enables of the accelerator top: write_w, write_in, read_w, read_in, read_o.
- Accepts a job descriptor from the host and sequences weight load, then input load, then compute, then pipeline drain, then output unload, with valid/ready handshakes on the host side.
- Latches the precision config (in_width, weight_width, s_in, s_weight) and holds it stable for the whole job.
- Sits between host/testbench and the accelerator top; one instance per accelerator.

Parameters:
- ARRAY_SIZE, 8, systolic array dimension.
- LOG_ARRAY_SIZE, 3, log2(ARRAY_SIZE).
- LOG_DEPTH, 5, log2 of buffer depth; beat counts are LOG_DEPTH bits wide.
- DRAIN_CYCLES, 2*ARRAY_SIZE, cycles waited after the last input read before unloading.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- abort  in  1  synchronous job cancel.
- cfg_n_beats  in  LOG_DEPTH  beats per phase minus 1 (0 means 1 beat, 31 means 32 beats).
- cfg_in_width, cfg_weight_width  in  4 each  precision config.
- cfg_s_in, cfg_s_weight  in  1 each  signedness config.
- in_width, weight_width  out  4 each  latched config to the accelerator.
- s_in, s_weight  out  1 each  latched config to the accelerator.
- w_valid / w_ready  in / out  1 each  weight load handshake.
- i_valid / i_ready  in / out  1 each  input load handshake.
- o_valid  out  1  obuf_out is valid this cycle.
- o_ready  in  1  host accepts output.
- write_w, write_in, read_w, read_in, read_o  out  1 each  accelerator buffer enables.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at job completion.
- perf_compute, perf_stall  out  32 each  performance counters (see Optional Feature).

Behaviour:
- Reset: state IDLE; every output is 0, including latched config, counters, o_valid and done.
- States: IDLE, LOAD_W, LOAD_I, COMPUTE, DRAIN, UNLOAD, DONE.
- IDLE:
  - On start, latch all cfg_* inputs and clear beat_cnt; next state LOAD_W, so w_ready is 1 in the following cycle.
  - start outside IDLE is ignored.
- LOAD_W:
  - w_ready = 1.
  - write_w = w_valid & w_ready, combinational, so the write happens in the same cycle as the handshake.
  - beat_cnt increments per accepted beat.
  - On the accepted beat with beat_cnt == n_beats: clear beat_cnt, go to LOAD_I.
  - w_valid low means hold; no write.
- LOAD_I: same rule using i_valid, i_ready and write_in; exits to COMPUTE.
- COMPUTE:
  - read_w = 1 in the first COMPUTE cycle only.
  - read_in = 1 for n_beats+1 consecutive cycles starting in that same first cycle.
  - Then go to DRAIN.
- DRAIN:
  - No enables asserted; wait exactly DRAIN_CYCLES cycles.
  - Then go to UNLOAD.
- UNLOAD:
  - read_o = o_ready & (beats issued < n_beats+1).
  - o_valid is read_o registered by one cycle, matching the 1-cycle buffer read latency.
  - Leave UNLOAD after the last o_valid has been presented.
- DONE:
  - done = 1 for one cycle; next state IDLE; busy drops in the same cycle IDLE is entered.
- Read and write enables are never asserted in the same cycle for the same buffer.
- abort:
  - In any state except IDLE: next state IDLE, all enables 0, o_valid 0, no done pulse.
  - abort and start in the same IDLE cycle: abort wins and start is ignored.
- rst mid-job: same effect as reset, synchronous, highest priority.
- beat_cnt wraps only through the explicit clear; n_beats = 31 yields exactly 32 beats.
- Latched config is updated only on start acceptance in IDLE.

Optional Feature:
- Macro: ACCEL_SEQ_PERF_EN.
- Defined:
  - perf_compute counts cycles spent in COMPUTE plus DRAIN.
  - perf_stall counts cycles in LOAD_W or LOAD_I with valid = 0, plus UNLOAD cycles with o_ready = 0 while beats remain.
  - Both counters clear on start acceptance and on rst, and saturate at all-ones.
- Undefined: both ports are tied to 0 and no counter flops are built; the port list is unchanged.

Decomposition:
- accel_pkg holds:
  - the seq_state_e enum (the 7 states);
  - LOG_DEPTH and COL_WIDTH = 10+LOG_ARRAY_SIZE;
  - a cfg_t struct {in_width, weight_width, s_in, s_weight, n_beats}.
- One sub-module: seq_beat_counter.
  - Ports: clr, inc, limit; outputs last and count.
  - Instantiated once and reused across phases, because the phases are mutually exclusive.

Test Plan:
- Basic job: rst, then start with n_beats = 3, every valid held high and o_ready = 1.
  - write_w is high 4 cycles, then write_in 4 cycles.
  - read_w pulses once, together with the first of 4 read_in cycles.
  - After 16 idle cycles, read_o is high 4 cycles, with o_valid lagging read_o by 1 cycle.
  - done pulses once; total latency from start to done is deterministic.
- Backpressure: toggle w_valid every cycle and hold o_ready low for 5 cycles mid-unload.
  - Still exactly 4 writes and 4 o_valid beats; no read_o while o_ready is 0.
- Boundaries: n_beats = 0 gives 1 beat per phase; n_beats = 31 gives exactly 32 beats, with no wrap errors.
- Abort in DRAIN: next cycle state is IDLE, busy = 0, all enables 0, no done pulse; a new start is then accepted.
- Config latching: start with in_width = 4 and weight_width = 2, then change cfg_* mid-job.
  - Outputs stay at 4 and 2 until the next start.
  - start asserted while busy is ignored.
- With ACCEL_SEQ_PERF_EN, on the basic job: perf_compute = 1+3+16 = 20 (1 COMPUTE cycle carrying read_w plus the first read_in, 3 more read_in cycles, 16 DRAIN cycles), and perf_stall = 0.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerator job sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package accel_pkg;

    localparam int LOG_ARRAY_SIZE = 3;
    localparam int LOG_DEPTH      = 5;
    localparam int COL_WIDTH      = 10 + LOG_ARRAY_SIZE;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_I  = 3'd2,
        COMPUTE = 3'd3,
        DRAIN   = 3'd4,
        UNLOAD  = 3'd5,
        DONE    = 3'd6
    } seq_state_e;

    // Precision config captured at job start and held for the whole job.
    typedef struct packed {
        logic [3:0]           in_width;
        logic [3:0]           weight_width;
        logic                 s_in;
        logic                 s_weight;
        logic [LOG_DEPTH-1:0] n_beats;
    } cfg_t;

endpackage

// File: rtl/accel_sequencer_beat_counter.sv
// Shared beat/cycle counter, reused by every sequencer phase since phases never overlap.
// Latency: count updates one cycle after inc; last is combinational on the current count.
// Backpressure: none; the owner decides when to increment or clear.
module seq_beat_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         last,
    output logic [W-1:0] count
);
    import accel_pkg::*;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over increment; the counter only ever wraps through an explicit clear.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == limit);

endmodule

// File: rtl/accel_sequencer.sv
// Job sequencer: weight load -> input load -> compute -> drain -> unload; perf counters under ACCEL_SEQ_PERF_EN.
// Latency: write enables follow the handshake combinationally; o_valid trails read_o by one cycle.
// Backpressure: w_valid/i_valid low holds the load phase, o_ready low holds the unload phase.
module accel_sequencer #(
    parameter int ARRAY_SIZE     = 8,
    parameter int LOG_ARRAY_SIZE = 3,
    parameter int LOG_DEPTH      = 5,
    parameter int DRAIN_CYCLES   = 2 * ARRAY_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [LOG_DEPTH-1:0] cfg_n_beats,
    input  logic [3:0]           cfg_in_width,
    input  logic [3:0]           cfg_weight_width,
    input  logic                 cfg_s_in,
    input  logic                 cfg_s_weight,
    output logic [3:0]           in_width,
    output logic [3:0]           weight_width,
    output logic                 s_in,
    output logic                 s_weight,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic                 write_w,
    output logic                 write_in,
    output logic                 read_w,
    output logic                 read_in,
    output logic                 read_o,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          perf_compute,
    output logic [31:0]          perf_stall
);
    import accel_pkg::*;

    // One counter serves beats and drain cycles, so it must hold the larger of the two ranges.
    // The default drain of 2*ARRAY_SIZE fits in LOG_ARRAY_SIZE+1 bits.
    localparam int CNT_W0 = (LOG_DEPTH > LOG_ARRAY_SIZE + 1) ? LOG_DEPTH : LOG_ARRAY_SIZE + 1;
    localparam int CNT_W  = (CNT_W0 > $clog2(DRAIN_CYCLES)) ? CNT_W0 : $clog2(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] DRAIN_LIMIT = CNT_W'(DRAIN_CYCLES - 1);

    seq_state_e state_q, state_d;
    cfg_t       cfg_q, cfg_d;
    logic       all_issued_q, all_issued_d;
    logic       o_valid_q, o_valid_d;

    logic             accept;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt_limit;
    logic [CNT_W-1:0] cnt_count;

    assign accept = (state_q == IDLE) && start && !abort;

    // The counter compares against the drain length in DRAIN and against n_beats elsewhere.
    assign cnt_limit = (state_q == DRAIN) ? DRAIN_LIMIT : CNT_W'(cfg_q.n_beats);

    seq_beat_counter #(
        .W (CNT_W)
    ) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .limit (cnt_limit),
        .last  (cnt_last),
        .count (cnt_count)
    );

    // Next-state, counter control and buffer enables; abort/rst squash every enable this cycle.
    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        all_issued_d = all_issued_q;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        w_ready      = 1'b0;
        i_ready      = 1'b0;
        write_w      = 1'b0;
        write_in     = 1'b0;
        read_w       = 1'b0;
        read_in      = 1'b0;
        read_o       = 1'b0;
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_clr      = 1'b1;
                all_issued_d = 1'b0;
                if (accept) begin
                    cfg_d.in_width     = cfg_in_width;
                    cfg_d.weight_width = cfg_weight_width;
                    cfg_d.s_in         = cfg_s_in;
                    cfg_d.s_weight     = cfg_s_weight;
                    cfg_d.n_beats      = cfg_n_beats;
                    state_d            = LOAD_W;
                end
            end
            LOAD_W: begin
                w_ready = 1'b1;
                write_w = w_valid;
                if (w_valid) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        cnt_clr = 1'b1;
                        state_d = LOAD_I;
                    end
                end
            end
            LOAD_I: begin
                i_ready  = 1'b1;
                write_in = i_valid;
                if (i_valid) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        cnt_clr = 1'b1;
                        state_d = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                // Weights are read once; inputs stream for n_beats+1 cycles from the same first cycle.
                read_w  = (cnt_count == '0);
                read_in = 1'b1;
                cnt_inc = 1'b1;
                if (cnt_last) begin
                    cnt_clr = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cnt_inc = 1'b1;
                if (cnt_last) begin
                    cnt_clr = 1'b1;
                    state_d = UNLOAD;
                end
            end
            UNLOAD: begin
                if (all_issued_q) begin
                    // Final cycle carries the o_valid of the last read; then finish.
                    all_issued_d = 1'b0;
                    state_d      = DONE;
                end else begin
                    read_o = o_ready;
                    if (o_ready) begin
                        cnt_inc = 1'b1;
                        if (cnt_last) begin
                            cnt_clr      = 1'b1;
                            all_issued_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            cnt_clr      = 1'b1;
            all_issued_d = 1'b0;
        end

        if (rst || (abort && (state_q != IDLE))) begin
            w_ready  = 1'b0;
            i_ready  = 1'b0;
            write_w  = 1'b0;
            write_in = 1'b0;
            read_w   = 1'b0;
            read_in  = 1'b0;
            read_o   = 1'b0;
            done     = 1'b0;
        end

        o_valid_d = read_o;
    end

    // State, latched config and output-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cfg_q        <= '0;
            all_issued_q <= 1'b0;
            o_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            all_issued_q <= all_issued_d;
            o_valid_q    <= o_valid_d;
        end
    end

    assign in_width     = cfg_q.in_width;
    assign weight_width = cfg_q.weight_width;
    assign s_in         = cfg_q.s_in;
    assign s_weight     = cfg_q.s_weight;
    assign o_valid      = o_valid_q;
    assign busy         = (state_q != IDLE);

`ifdef ACCEL_SEQ_PERF_EN
    logic [31:0] perf_compute_q, perf_compute_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        compute_tick;
    logic        stall_tick;

    // Saturating perf counters, cleared whenever a new job is accepted.
    always_comb begin
        compute_tick   = (state_q == COMPUTE) || (state_q == DRAIN);
        stall_tick     = ((state_q == LOAD_W) && !w_valid) ||
                         ((state_q == LOAD_I) && !i_valid) ||
                         ((state_q == UNLOAD) && !all_issued_q && !o_ready);
        perf_compute_d = perf_compute_q;
        perf_stall_d   = perf_stall_q;
        if (accept) begin
            perf_compute_d = '0;
            perf_stall_d   = '0;
        end else begin
            if (compute_tick && (perf_compute_q != '1)) begin
                perf_compute_d = perf_compute_q + 32'd1;
            end
            if (stall_tick && (perf_stall_q != '1)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_compute_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_compute_q <= perf_compute_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_compute = perf_compute_q;
    assign perf_stall   = perf_stall_q;
`else
    assign perf_compute = '0;
    assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_accel_sequencer.sv
module tb_accel_sequencer;

    localparam int DRAIN = 16;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [4:0]  cfg_n_beats;
    logic [3:0]  cfg_in_width, cfg_weight_width;
    logic        cfg_s_in, cfg_s_weight;
    logic [3:0]  in_width, weight_width;
    logic        s_in, s_weight;
    logic        w_valid, w_ready, i_valid, i_ready, o_valid, o_ready;
    logic        write_w, write_in, read_w, read_in, read_o, busy, done;
    logic [31:0] perf_compute, perf_stall;

    always #5 clk = ~clk;

    accel_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .cfg_n_beats      (cfg_n_beats),
        .cfg_in_width     (cfg_in_width),
        .cfg_weight_width (cfg_weight_width),
        .cfg_s_in         (cfg_s_in),
        .cfg_s_weight     (cfg_s_weight),
        .in_width         (in_width),
        .weight_width     (weight_width),
        .s_in             (s_in),
        .s_weight         (s_weight),
        .w_valid          (w_valid),
        .w_ready          (w_ready),
        .i_valid          (i_valid),
        .i_ready          (i_ready),
        .o_valid          (o_valid),
        .o_ready          (o_ready),
        .write_w          (write_w),
        .write_in         (write_in),
        .read_w           (read_w),
        .read_in          (read_in),
        .read_o           (read_o),
        .busy             (busy),
        .done             (done),
        .perf_compute     (perf_compute),
        .perf_stall       (perf_stall)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Job-level reference: which phase the job is in, plus plain counts.
    typedef enum int {M_IDLE, M_LOADW, M_LOADI, M_TIMED, M_UNLOAD, M_DONE} mmode_e;
    mmode_e      m_mode;
    int          m_nb, m_cnt, m_t0, m_issued, g_cyc;
    bit          m_prev_ro;
    logic [3:0]  m_iw, m_ww;
    bit          m_si, m_sw;
    logic [31:0] m_pc, m_ps;

    bit e_wr, e_ir, e_ww, e_wi, e_rw, e_ri, e_ro, e_ov, e_busy, e_done;

    // Per-job tallies of what the DUT actually did.
    int t_ww, t_wi, t_rw, t_ri, t_ro, t_ov, t_done, t_start, t_done_cyc, t_last_ri, t_first_ro;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, g_cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_nb = 1; m_cnt = 0; m_t0 = 0; m_issued = 0; m_prev_ro = 0;
        m_iw = '0; m_ww = '0; m_si = 0; m_sw = 0; m_pc = '0; m_ps = '0;
    endtask

    task automatic clear_tally();
        t_ww = 0; t_wi = 0; t_rw = 0; t_ri = 0; t_ro = 0; t_ov = 0; t_done = 0;
        t_start = -1; t_done_cyc = -1; t_last_ri = -1; t_first_ro = -1;
    endtask

    // Expected combinational outputs for this cycle from the model phase and current inputs.
    task automatic predict();
        bit kill;
        int k;
        kill = rst || (abort && m_mode != M_IDLE);
        k = g_cyc - m_t0;
        e_wr = 0; e_ir = 0; e_ww = 0; e_wi = 0; e_rw = 0; e_ri = 0; e_ro = 0; e_done = 0;
        case (m_mode)
            M_LOADW:  begin e_wr = !kill; e_ww = w_valid && !kill; end
            M_LOADI:  begin e_ir = !kill; e_wi = i_valid && !kill; end
            M_TIMED:  begin e_ri = (k < m_nb) && !kill; e_rw = (k == 0) && !kill; end
            M_UNLOAD: e_ro = o_ready && (m_issued < m_nb) && !kill;
            M_DONE:   e_done = !kill;
            default:  ;
        endcase
        e_busy = (m_mode != M_IDLE);
        e_ov   = m_prev_ro;
    endtask

    // Advance the model across one clock edge using the inputs held during the cycle.
    task automatic advance();
        int k;
        bit comp_t, stall_t;
        k = g_cyc - m_t0;
        comp_t  = (m_mode == M_TIMED);
        stall_t = (m_mode == M_LOADW && !w_valid) || (m_mode == M_LOADI && !i_valid) ||
                  (m_mode == M_UNLOAD && m_issued < m_nb && !o_ready);
        if (rst) begin
            model_reset();
        end else begin
            if (comp_t && m_pc != 32'hFFFF_FFFF) m_pc++;
            if (stall_t && m_ps != 32'hFFFF_FFFF) m_ps++;
            m_prev_ro = e_ro;
            if (abort && m_mode != M_IDLE) begin
                m_mode = M_IDLE;
            end else begin
                case (m_mode)
                    M_IDLE: if (start && !abort) begin
                        m_iw = cfg_in_width; m_ww = cfg_weight_width;
                        m_si = cfg_s_in; m_sw = cfg_s_weight;
                        m_nb = int'(cfg_n_beats) + 1; m_cnt = 0;
                        m_pc = '0; m_ps = '0;
                        m_mode = M_LOADW;
                    end
                    M_LOADW: if (w_valid) begin
                        m_cnt++;
                        if (m_cnt == m_nb) begin m_cnt = 0; m_mode = M_LOADI; end
                    end
                    M_LOADI: if (i_valid) begin
                        m_cnt++;
                        if (m_cnt == m_nb) begin m_cnt = 0; m_mode = M_TIMED; m_t0 = g_cyc + 1; end
                    end
                    M_TIMED: if (k == m_nb + DRAIN - 1) begin m_mode = M_UNLOAD; m_issued = 0; end
                    M_UNLOAD: begin
                        if (m_issued == m_nb) m_mode = M_DONE;
                        else if (e_ro) m_issued++;
                    end
                    M_DONE: m_mode = M_IDLE;
                    default: ;
                endcase
            end
        end
        g_cyc++;
    endtask

    // One cycle: settle, compare every output against the model, tally, clock, advance.
    task automatic tick();
        logic [63:0] exp_perf;
        #1;
        predict();
        check("ctrl", {54'd0, w_ready, i_ready, write_w, write_in, read_w, read_in, read_o, o_valid, busy, done},
                      {54'd0, e_wr, e_ir, e_ww, e_wi, e_rw, e_ri, e_ro, e_ov, e_busy, e_done});
        check("cfg", {54'd0, in_width, weight_width, s_in, s_weight}, {54'd0, m_iw, m_ww, m_si, m_sw});
`ifdef ACCEL_SEQ_PERF_EN
        exp_perf = {m_pc, m_ps};
`else
        exp_perf = 64'd0;
`endif
        check("perf", {perf_compute, perf_stall}, exp_perf);
        t_ww += int'(write_w); t_wi += int'(write_in); t_rw += int'(read_w);
        t_ri += int'(read_in); t_ro += int'(read_o); t_ov += int'(o_valid); t_done += int'(done);
        if (read_in === 1'b1) t_last_ri = g_cyc;
        if (read_o === 1'b1 && t_first_ro < 0) t_first_ro = g_cyc;
        if (done === 1'b1) t_done_cyc = g_cyc;
        @(posedge clk);
        advance();
        @(negedge clk);
    endtask

    // kind: 0 plain, 1 toggled w_valid + 5-cycle o_ready stall, 2 random abort,
    //       3 reset mid input-load, 4 start+abort collision before the real start.
    task automatic run_job(input int n, input int pv, input int pr, input int kind, input int abort_k,
                           input logic [3:0] iw, input logic [3:0] ww);
        int  cyc = 0;
        int  stall_left = 0;
        bit  started = 0;
        bit  stalled = 0;
        bit  did_rst = 0;
        clear_tally();
        forever begin
            rst   = 1'b0;
            abort = 1'b0;
            if (!started) begin
                start = 1'b1;
                cfg_n_beats = 5'(n); cfg_in_width = iw; cfg_weight_width = ww;
                cfg_s_in = 1'($urandom); cfg_s_weight = 1'($urandom);
                if (kind == 4 && cyc == 0) abort = 1'b1;
            end else begin
                start = ($urandom % 4 == 0);
                cfg_n_beats = 5'($urandom); cfg_in_width = 4'($urandom); cfg_weight_width = 4'($urandom);
                cfg_s_in = 1'($urandom); cfg_s_weight = 1'($urandom);
            end
            w_valid = (kind == 1) ? 1'(cyc % 2) : ($urandom_range(0, 99) < pv);
            i_valid = ($urandom_range(0, 99) < pv);
            o_ready = ($urandom_range(0, 99) < pr);
            if (kind == 1) begin
                if (m_mode == M_UNLOAD && m_issued == 2 && !stalled) begin stall_left = 5; stalled = 1; end
                if (stall_left > 0) begin o_ready = 1'b0; stall_left--; end
            end
            if (abort_k >= 0 && m_mode == M_TIMED && (g_cyc - m_t0) == abort_k) abort = 1'b1;
            if (kind == 2 && started && ($urandom % 64 == 0)) abort = 1'b1;
            if (kind == 3 && m_mode == M_LOADI && m_cnt == 1 && !did_rst) begin rst = 1'b1; did_rst = 1; end
            tick();
            cyc++;
            if (m_mode != M_IDLE) begin
                if (!started) t_start = g_cyc - 1;
                started = 1;
            end else if (started) begin
                break;
            end
            if (cyc > 5000) begin
                n_checks++; n_fail++;
                $display("FAIL job_timeout: no return to idle after %0d cycles", cyc);
                break;
            end
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        model_reset();
        g_cyc = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_n_beats = '0; cfg_in_width = '0;
        cfg_weight_width = '0; cfg_s_in = 1'b0; cfg_s_weight = 1'b0;
        w_valid = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_ovalid_done", {62'd0, o_valid, done}, 64'd0);
        check("reset_cfg", {54'd0, in_width, weight_width, s_in, s_weight}, 64'd0);
        check("reset_perf", {perf_compute, perf_stall}, 64'd0);

        // Basic job: n_beats = 3, everything always ready.
        run_job(3, 100, 100, 0, -1, 4'd4, 4'd2);
        check("basic_write_w", t_ww, 4);
        check("basic_write_in", t_wi, 4);
        check("basic_read_w", t_rw, 1);
        check("basic_read_in", t_ri, 4);
        check("basic_read_o", t_ro, 4);
        check("basic_o_valid", t_ov, 4);
        check("basic_done", t_done, 1);
        check("basic_latency", t_done_cyc - t_start, 34);
        check("basic_drain_gap", t_first_ro - t_last_ri, 17);
        check("basic_cfg_held", {56'd0, in_width, weight_width}, {56'd0, 4'd4, 4'd2});
        check("model_perf_compute", m_pc, 20);
        check("model_perf_stall", m_ps, 0);
`ifdef ACCEL_SEQ_PERF_EN
        check("basic_perf_compute", perf_compute, 20);
        check("basic_perf_stall", perf_stall, 0);
`endif

        // Backpressure: toggled w_valid, o_ready held low 5 cycles mid-unload.
        run_job(3, 100, 100, 1, -1, 4'd8, 4'd8);
        check("bp_write_w", t_ww, 4);
        check("bp_read_o", t_ro, 4);
        check("bp_o_valid", t_ov, 4);
        check("bp_done", t_done, 1);

        // Boundaries.
        run_job(0, 100, 100, 0, -1, 4'd1, 4'd1);
        check("n0_write_w", t_ww, 1);
        check("n0_read_in", t_ri, 1);
        check("n0_o_valid", t_ov, 1);
        run_job(31, 100, 100, 0, -1, 4'd2, 4'd3);
        check("n31_write_w", t_ww, 32);
        check("n31_write_in", t_wi, 32);
        check("n31_read_in", t_ri, 32);
        check("n31_o_valid", t_ov, 32);

        // Abort in DRAIN (6th cycle after compute of a 4-beat job), then a fresh job.
        run_job(3, 100, 100, 0, 4 + 5, 4'd5, 4'd6);
        check("abort_done", t_done, 0);
        check("abort_read_o", t_ro, 0);
        run_job(2, 100, 100, 4, -1, 4'd7, 4'd1);
        check("after_abort_done", t_done, 1);
        check("after_abort_cfg", {56'd0, in_width, weight_width}, {56'd0, 4'd7, 4'd1});

        // Reset in the middle of input load.
        run_job(5, 80, 100, 3, -1, 4'd3, 4'd3);
        check("rst_mid_done", t_done, 0);
        check("rst_mid_cfg", {56'd0, in_width, weight_width}, 64'd0);

        // Randomized jobs.
        for (int j = 0; j < 24; j++) begin
            run_job($urandom_range(0, 31), $urandom_range(30, 100), $urandom_range(30, 100),
                    (j % 3 == 2) ? 2 : 0, -1, 4'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
